// File: rtl/fir_param_pkg.sv
// Shared definitions for the parametrised FIR peripheral.
//   - CSR word addresses and CTRL/STATUS bit positions
//   - MAC sequencer state encoding
//   - clog2() used to size the accumulator and tap index
package fir_param_pkg;

  localparam logic [31:0] ADDR_CTRL   = 32'd0;
  localparam logic [31:0] ADDR_STATUS = 32'd1;
  localparam logic [31:0] ADDR_X      = 32'd2;
  localparam logic [31:0] ADDR_Y      = 32'd3;
  localparam logic [31:0] ADDR_COEF0  = 32'd4;

  localparam int CTRL_SAT   = 5;
  localparam int CTRL_ROUND = 6;
  localparam int CTRL_IE    = 7;
  localparam int CTRL_CLEAR = 8;

  localparam int STAT_BUSY   = 0;
  localparam int STAT_YVALID = 1;
  localparam int STAT_OVR    = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_DONE = 2'd2
  } mac_state_t;

  // Smallest r with 2**r >= value (value >= 2).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((longint'(1) << i) < longint'(value)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fir_param_filter_if.sv
// Memory-mapped slave bus of the FIR peripheral.
//   master: drives ChipSelect, Address, Write, Read, WriteData
//   slave : drives ReadData (registered), WaitRequest (stall), Irq (level)
interface fir_param_filter_if #(
  parameter int ADDR_W = 4
);
  logic              ChipSelect;
  logic [ADDR_W-1:0] Address;
  logic              Write;
  logic              Read;
  logic [31:0]       WriteData;
  logic [31:0]       ReadData;
  logic              WaitRequest;
  logic              Irq;

  modport master (
    output ChipSelect, Address, Write, Read, WriteData,
    input  ReadData, WaitRequest, Irq
  );

  modport slave (
    input  ChipSelect, Address, Write, Read, WriteData,
    output ReadData, WaitRequest, Irq
  );
endinterface

// File: rtl/fir_mac_seq.sv
// Sequential single-MAC FIR core: sample delay line, one multiply-accumulate
// per clock over TAPS taps, then shift/round/saturate into the result register.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   clear               soft clear: aborts MAC, zeroes samples/acc/Y/flags
//   x_wr, x_in          accepted sample write (only issued while idle)
//   y_rd                accepted read of Y (clears YVALID)
//   ovr_clr             write-one-to-clear of the overrun flag
//   coef                coefficient vector, coef[k] multiplies x[k]
//   shift, sat, round   post-processing controls, sampled on the DONE edge
//   busy, yvalid, ovr   status flags
//   y, x_last           result register and newest sample
module fir_mac_seq
  import fir_param_pkg::*;
#(
  parameter int TAPS   = 8,
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int OUT_W  = 24
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clear,
  input  logic                          x_wr,
  input  logic [DATA_W-1:0]             x_in,
  input  logic                          y_rd,
  input  logic                          ovr_clr,
  input  logic [TAPS-1:0][COEF_W-1:0]   coef,
  input  logic [4:0]                    shift,
  input  logic                          sat,
  input  logic                          round,
  output logic                          busy,
  output logic                          yvalid,
  output logic                          ovr,
  output logic [OUT_W-1:0]              y,
  output logic [DATA_W-1:0]             x_last
);
  localparam int IDX_W = clog2(TAPS);
  localparam int ACC_W = DATA_W + COEF_W + clog2(TAPS);
  // Headroom for a rounding bias of up to 2**30 on top of the accumulator.
  localparam int PW    = ACC_W + 33;
  localparam longint SAT_MAX_L = (longint'(1) <<< (OUT_W - 1)) - 1;
  localparam logic signed [PW-1:0] SAT_MAX = PW'(SAT_MAX_L);
  localparam logic signed [PW-1:0] SAT_MIN = -SAT_MAX - PW'(1);

  mac_state_t               state_reg;
  logic [IDX_W-1:0]         idx_reg;
  logic signed [ACC_W-1:0]  acc_reg;
  logic [DATA_W-1:0]        x_reg [TAPS];
  logic [OUT_W-1:0]         y_reg;
  logic                     yvalid_reg;
  logic                     ovr_reg;

  logic signed [DATA_W-1:0]        x_sel;
  logic signed [COEF_W-1:0]        c_sel;
  logic signed [DATA_W+COEF_W-1:0] prod;
  logic signed [ACC_W-1:0]         acc_next;

  assign x_sel    = x_reg[idx_reg];
  assign c_sel    = coef[idx_reg];
  assign prod     = x_sel * c_sel;
  assign acc_next = acc_reg + ACC_W'(prod);

  // Optional round-half-up bias, arithmetic shift, then clamp or wrap to OUT_W.
  function automatic logic [OUT_W-1:0] post(input logic signed [ACC_W-1:0] acc_in,
                                            input logic [4:0] sh,
                                            input logic rnd,
                                            input logic sat_en);
    logic signed [PW-1:0] bias;
    logic signed [PW-1:0] a;
    logic signed [PW-1:0] s;
    bias = '0;
    if (rnd && sh != 5'd0) bias[sh - 5'd1] = 1'b1;
    a = PW'(acc_in) + bias;
    s = a >>> sh;
    if (sat_en) begin
      if (s > SAT_MAX)      s = SAT_MAX;
      else if (s < SAT_MIN) s = SAT_MIN;
    end
    return s[OUT_W-1:0];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      idx_reg    <= '0;
      acc_reg    <= '0;
      y_reg      <= '0;
      yvalid_reg <= 1'b0;
      ovr_reg    <= 1'b0;
      for (int k = 0; k < TAPS; k++) x_reg[k] <= '0;
    end else if (clear) begin
      state_reg  <= ST_IDLE;
      idx_reg    <= '0;
      acc_reg    <= '0;
      y_reg      <= '0;
      yvalid_reg <= 1'b0;
      ovr_reg    <= 1'b0;
      for (int k = 0; k < TAPS; k++) x_reg[k] <= '0;
    end else begin
      if (y_rd)    yvalid_reg <= 1'b0;
      if (ovr_clr) ovr_reg    <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (x_wr) begin
            x_reg[0] <= x_in;
            for (int k = 1; k < TAPS; k++) x_reg[k] <= x_reg[k-1];
            acc_reg   <= '0;
            idx_reg   <= '0;
            state_reg <= ST_MAC;
          end
        end
        ST_MAC: begin
          acc_reg <= acc_next;
          if (idx_reg == IDX_W'(TAPS - 1)) state_reg <= ST_DONE;
          else                             idx_reg   <= idx_reg + 1'b1;
        end
        ST_DONE: begin
          y_reg      <= post(acc_reg, shift, round, sat);
          // Set wins over a concurrent Y read; a result still pending and
          // not being read this edge is lost, which is an overrun.
          yvalid_reg <= 1'b1;
          if (yvalid_reg && !y_rd) ovr_reg <= 1'b1;
          state_reg  <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign busy   = (state_reg != ST_IDLE);
  assign yvalid = yvalid_reg;
  assign ovr    = ovr_reg;
  assign y      = y_reg;
  assign x_last = x_reg[0];

endmodule

// File: rtl/fir_param_filter.sv
// Parametrised FIR filter peripheral with a CSR slave port.
// Ports:
//   clk    clock
//   RstN   asynchronous active-low reset
//   bus    slave modport: ChipSelect/Address/Write/Read/WriteData in,
//          ReadData (registered, valid the cycle after an accepted read),
//          WaitRequest (stalls X/COEF writes while the MAC is busy), Irq.
// Map: 0 CTRL, 1 STATUS, 2 X, 3 Y, 4..4+TAPS-1 COEF[k].
module fir_param_filter
  import fir_param_pkg::*;
#(
  parameter int TAPS   = 8,
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int OUT_W  = 24,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              RstN,
  fir_param_filter_if.slave bus
);
  localparam int IDX_W = clog2(TAPS);

  logic [ADDR_W-1:0] addr;
  logic [31:0]       addr_w;
  logic [31:0]       coef_off;
  logic [IDX_W-1:0]  coef_idx;
  logic is_ctrl, is_status, is_x, is_y, is_coef;
  logic busy, yvalid, ovr;
  logic wait_req, wr_acc, rd_acc;
  logic ctrl_wr, clear, x_wr, ovr_clr, y_rd;

  logic [4:0] shift_reg;
  logic       sat_reg, round_reg, ie_reg;

  logic [COEF_W-1:0]             coef_reg [TAPS];
  logic [TAPS-1:0][COEF_W-1:0]   coef_flat;
  logic [OUT_W-1:0]              y;
  logic [DATA_W-1:0]             x_last;
  logic [31:0]                   rd_mux;
  logic [31:0]                   read_data_reg;
  logic                          unused_bits;

  assign addr      = bus.Address;
  assign addr_w    = 32'(addr);
  assign coef_off  = addr_w - ADDR_COEF0;
  assign coef_idx  = coef_off[IDX_W-1:0];
  assign is_ctrl   = (addr_w == ADDR_CTRL);
  assign is_status = (addr_w == ADDR_STATUS);
  assign is_x      = (addr_w == ADDR_X);
  assign is_y      = (addr_w == ADDR_Y);
  assign is_coef   = (addr_w >= ADDR_COEF0) && (addr_w < ADDR_COEF0 + 32'(TAPS));

  // Coefficients feed the running MAC, so they are frozen like X while busy.
  assign wait_req = bus.ChipSelect && bus.Write && (is_x || is_coef) && busy;
  assign wr_acc   = bus.ChipSelect && bus.Write && !wait_req;
  assign rd_acc   = bus.ChipSelect && bus.Read && !bus.Write;

  assign ctrl_wr  = wr_acc && is_ctrl;
  assign clear    = ctrl_wr && bus.WriteData[CTRL_CLEAR];
  assign x_wr     = wr_acc && is_x;
  assign ovr_clr  = wr_acc && is_status && bus.WriteData[STAT_OVR];
  assign y_rd     = rd_acc && is_y;

  assign unused_bits = ^{bus.WriteData, coef_off};

  always_ff @(posedge clk or negedge RstN) begin
    if (!RstN) begin
      shift_reg <= '0;
      sat_reg   <= 1'b0;
      round_reg <= 1'b0;
      ie_reg    <= 1'b0;
    end else if (ctrl_wr) begin
      shift_reg <= bus.WriteData[4:0];
      sat_reg   <= bus.WriteData[CTRL_SAT];
      round_reg <= bus.WriteData[CTRL_ROUND];
      ie_reg    <= bus.WriteData[CTRL_IE];
    end
  end

  for (genvar gi = 0; gi < TAPS; gi++) begin : g_coef
    always_ff @(posedge clk or negedge RstN) begin
      if (!RstN)
        coef_reg[gi] <= '0;
      else if (wr_acc && is_coef && coef_idx == IDX_W'(gi))
        coef_reg[gi] <= bus.WriteData[COEF_W-1:0];
    end
    assign coef_flat[gi] = coef_reg[gi];
  end

  fir_mac_seq #(
    .TAPS   (TAPS),
    .DATA_W (DATA_W),
    .COEF_W (COEF_W),
    .OUT_W  (OUT_W)
  ) u_mac (
    .clk     (clk),
    .rst_n   (RstN),
    .clear   (clear),
    .x_wr    (x_wr),
    .x_in    (bus.WriteData[DATA_W-1:0]),
    .y_rd    (y_rd),
    .ovr_clr (ovr_clr),
    .coef    (coef_flat),
    .shift   (shift_reg),
    .sat     (sat_reg),
    .round   (round_reg),
    .busy    (busy),
    .yvalid  (yvalid),
    .ovr     (ovr),
    .y       (y),
    .x_last  (x_last)
  );

  // CLEAR is a pulse, so CTRL bit 8 always reads back as 0.
  always_comb begin
    rd_mux = '0;
    if (is_ctrl) begin
      rd_mux = {23'd0, ie_reg, round_reg, sat_reg, shift_reg};
    end else if (is_status) begin
      rd_mux[STAT_BUSY]   = busy;
      rd_mux[STAT_YVALID] = yvalid;
      rd_mux[STAT_OVR]    = ovr;
    end else if (is_x) begin
      rd_mux = 32'($signed(x_last));
    end else if (is_y) begin
      rd_mux = 32'($signed(y));
    end else if (is_coef) begin
      rd_mux = 32'($signed(coef_reg[coef_idx]));
    end
  end

  always_ff @(posedge clk or negedge RstN) begin
    if (!RstN)       read_data_reg <= '0;
    else if (rd_acc) read_data_reg <= rd_mux;
  end

  assign bus.ReadData    = read_data_reg;
  assign bus.WaitRequest = wait_req;
  assign bus.Irq         = yvalid && ie_reg;

endmodule

// File: tb/tb_fir_param_filter.sv
// Self-checking bench for fir_param_filter (TAPS=8, 8-bit data/coef, OUT_W=16).
module tb_fir_param_filter;
  localparam int TAPS   = 8;
  localparam int DATA_W = 8;
  localparam int COEF_W = 8;
  localparam int OUT_W  = 16;
  localparam int ADDR_W = 4;
  localparam int A_CTRL = 0, A_STAT = 1, A_X = 2, A_Y = 3, A_COEF = 4;

  logic clk = 1'b0;
  logic RstN = 1'b0;
  always #5 clk = ~clk;

  fir_param_filter_if #(.ADDR_W(ADDR_W)) bus ();

  fir_param_filter #(
    .TAPS(TAPS), .DATA_W(DATA_W), .COEF_W(COEF_W), .OUT_W(OUT_W), .ADDR_W(ADDR_W)
  ) dut (
    .clk  (clk),
    .RstN (RstN),
    .bus  (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int coef_m [TAPS];
  int xs_m   [TAPS];
  int y_m;
  bit yvalid_m, ovr_m;
  int shift_m;
  bit sat_m, round_m, ie_m;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int sext8(input int v);
    logic [7:0] b;
    b = v[7:0];
    return int'($signed(b));
  endfunction

  function automatic int post_m(input longint acc);
    longint a, s;
    a = acc + ((round_m && shift_m != 0) ? (longint'(1) << (shift_m - 1)) : longint'(0));
    s = a >>> shift_m;
    if (sat_m) begin
      if (s > 32767) s = 32767;
      else if (s < -32768) s = -32768;
    end else begin
      s = s & 64'hFFFF;
      if (s >= 32768) s = s - 65536;
    end
    return int'(s);
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < TAPS; k++) begin coef_m[k] = 0; xs_m[k] = 0; end
    y_m = 0; yvalid_m = 0; ovr_m = 0;
    shift_m = 0; sat_m = 0; round_m = 0; ie_m = 0;
  endfunction

  function automatic void model_sample(input int x);
    longint acc;
    for (int k = TAPS - 1; k > 0; k--) xs_m[k] = xs_m[k-1];
    xs_m[0] = sext8(x);
    acc = 0;
    for (int k = 0; k < TAPS; k++) acc += longint'(xs_m[k]) * longint'(coef_m[k]);
    if (yvalid_m) ovr_m = 1;
    yvalid_m = 1;
    y_m = post_m(acc);
  endfunction

  function automatic logic [31:0] status_exp();
    logic [31:0] s;
    s = '0;
    s[1] = yvalid_m;
    s[2] = ovr_m;
    return s;
  endfunction

  task automatic idle_bus();
    bus.ChipSelect = 1'b0; bus.Write = 1'b0; bus.Read = 1'b0;
    bus.Address = '0; bus.WriteData = '0;
  endtask

  task automatic bus_write(input int addr, input logic [31:0] data, output int stalls);
    bit ok;
    ok = 0;
    stalls = 0;
    bus.ChipSelect = 1'b1; bus.Write = 1'b1; bus.Read = 1'b0;
    bus.Address = ADDR_W'(addr); bus.WriteData = data;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (!bus.WaitRequest) begin ok = 1; break; end
      stalls++;
    end
    if (!ok) check("write_timeout", 32'(ok), 32'd1);
    @(posedge clk);
    #1;
    idle_bus();
  endtask

  task automatic wr(input int addr, input logic [31:0] data);
    int s;
    bus_write(addr, data, s);
  endtask

  task automatic bus_read(input int addr, output logic [31:0] data);
    bus.ChipSelect = 1'b1; bus.Write = 1'b0; bus.Read = 1'b1;
    bus.Address = ADDR_W'(addr);
    @(negedge clk);
    @(posedge clk);
    #1;
    data = bus.ReadData;
    idle_bus();
  endtask

  task automatic wait_idle();
    logic [31:0] d;
    bit ok;
    ok = 0;
    for (int n = 0; n < 40; n++) begin
      bus_read(A_STAT, d);
      if (!d[0]) begin ok = 1; break; end
    end
    if (!ok) check("busy_timeout", 32'(ok), 32'd1);
  endtask

  task automatic set_ctrl(input int sh, input bit sat, input bit rnd, input bit ie);
    logic [31:0] w;
    w = '0;
    w[4:0] = 5'(sh); w[5] = sat; w[6] = rnd; w[7] = ie;
    wr(A_CTRL, w);
    shift_m = sh; sat_m = sat; round_m = rnd; ie_m = ie;
  endtask

  task automatic set_coef(input int k, input int c);
    wr(A_COEF + k, 32'(c));
    coef_m[k] = sext8(c);
  endtask

  task automatic send_x(input int x);
    wr(A_X, 32'(x));
    model_sample(x);
    wait_idle();
  endtask

  task automatic read_y(output logic [31:0] d);
    bus_read(A_Y, d);
    yvalid_m = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    int stalls, busy_cnt, x;
    logic [31:0] last_status;

    idle_bus();
    model_reset();
    RstN = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_readdata", bus.ReadData, 32'd0);
    check("reset_waitreq", 32'(bus.WaitRequest), 32'd0);
    check("reset_irq", 32'(bus.Irq), 32'd0);
    RstN = 1'b1;
    @(posedge clk); #1;
    bus_read(A_CTRL, d);   check("reset_ctrl", d, 32'd0);
    bus_read(A_STAT, d);   check("reset_status", d, 32'd0);
    bus_read(A_Y, d);      check("reset_y", d, 32'd0);

    // Impulse response with COEF[k]=k+1
    for (int k = 0; k < TAPS; k++) set_coef(k, k + 1);
    bus_read(A_COEF + 3, d); check("coef3_readback", d, 32'd4);
    set_ctrl(0, 0, 0, 0);
    for (int i = 0; i <= TAPS; i++) begin
      send_x(i == 0 ? 1 : 0);
      read_y(d);
      check($sformatf("impulse_%0d", i), d, (i < TAPS) ? 32'(i + 1) : 32'd0);
    end

    // Latency: BUSY for TAPS+1 edges, then YVALID
    wr(A_X, 32'd5);
    model_sample(5);
    busy_cnt = 0;
    last_status = '0;
    for (int n = 0; n < 20; n++) begin
      bus_read(A_STAT, d);
      if (d[0]) busy_cnt++;
      else begin last_status = d; break; end
    end
    check("latency_busy_edges", 32'(busy_cnt), 32'(TAPS + 1));
    check("latency_status_done", last_status, status_exp());

    // Stall: second X write held off until idle, accepted once
    wr(A_X, 32'(-7));
    model_sample(-7);
    bus_write(A_X, 32'd9, stalls);
    model_sample(9);
    check("stall_cycles", 32'(stalls), 32'(TAPS + 1));
    wait_idle();
    read_y(d);             check("stall_y", d, 32'(y_m));
    bus_read(A_STAT, d);   check("stall_status_ovr", d, status_exp());
    wr(A_STAT, 32'h3);     // BUSY/YVALID bits are ignored
    bus_read(A_STAT, d);   check("status_w1c_other_bits", d, status_exp());
    wr(A_STAT, 32'h4);
    ovr_m = 0;
    bus_read(A_STAT, d);   check("status_w1c_ovr", d, status_exp());

    // Randomised samples, coefficients and post-processing controls
    for (int k = 0; k < TAPS; k++) set_coef(k, int'($urandom_range(0, 255)));
    for (int i = 0; i < 10; i++) begin
      set_ctrl(int'($urandom_range(0, 7)), bit'($urandom_range(0, 1)),
               bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
      set_coef(int'($urandom_range(0, TAPS - 1)), int'($urandom_range(0, 255)));
      x = int'($urandom_range(0, 255));
      send_x(x);
      bus_read(A_X, d);    check($sformatf("rand_xlast_%0d", i), d, 32'(sext8(x)));
      check($sformatf("rand_irq_%0d", i), 32'(bus.Irq), 32'(yvalid_m & ie_m));
      if ($urandom_range(0, 1) == 1) begin
        read_y(d);         check($sformatf("rand_y_%0d", i), d, 32'(y_m));
      end
      bus_read(A_STAT, d); check($sformatf("rand_status_%0d", i), d, status_exp());
    end
    wr(A_STAT, 32'h4);
    ovr_m = 0;

    // Round / shift
    for (int k = 0; k < TAPS; k++) set_coef(k, (k == 0) ? 1 : 0);
    set_ctrl(1, 0, 1, 0);
    send_x(3);  read_y(d); check("round_on", d, 32'd2);
    set_ctrl(1, 0, 0, 0);
    send_x(3);  read_y(d); check("round_off", d, 32'd1);
    send_x(-3); read_y(d); check("shift_negative", d, 32'hFFFFFFFE);

    // Saturation vs wrap at OUT_W=16 (acc = 8*127*127 = 129032)
    for (int k = 0; k < TAPS; k++) set_coef(k, 127);
    set_ctrl(0, 1, 0, 0);
    for (int i = 0; i < TAPS; i++) send_x(127);
    read_y(d); check("saturate_on", d, 32'h00007FFF);
    set_ctrl(0, 0, 0, 0);
    send_x(127);
    read_y(d); check("saturate_off", d, 32'hFFFFF808);
    wr(A_STAT, 32'h4);
    ovr_m = 0;

    // Overrun and interrupt
    set_ctrl(0, 0, 0, 1);
    send_x(1);
    send_x(2);
    bus_read(A_STAT, d);   check("ovr_status", d, 32'h6);
    check("irq_set", 32'(bus.Irq), 32'd1);
    read_y(d);             check("ovr_y", d, 32'(y_m));
    check("irq_cleared", 32'(bus.Irq), 32'd0);
    wr(A_STAT, 32'h4);
    ovr_m = 0;
    bus_read(A_STAT, d);   check("ovr_w1c", d, 32'd0);

    // Abort with CLEAR on the third MAC edge
    wr(A_X, 32'd50);
    @(posedge clk); @(posedge clk); #1;
    wr(A_CTRL, 32'h180);
    for (int k = 0; k < TAPS; k++) xs_m[k] = 0;
    y_m = 0; yvalid_m = 0; ovr_m = 0;
    bus_read(A_STAT, d);   check("abort_status", d, 32'd0);
    bus_read(A_Y, d);      check("abort_y", d, 32'd0);
    bus_read(A_CTRL, d);   check("abort_ctrl_kept", d, 32'h80);
    bus_read(A_COEF, d);   check("abort_coef_kept", d, 32'd127);
    bus_read(A_X, d);      check("abort_xline", d, 32'd0);
    check("abort_irq", 32'(bus.Irq), 32'd0);
    send_x(2);
    read_y(d);             check("after_abort_y", d, 32'(y_m));

    // Reset in the middle of a MAC
    wr(A_X, 32'd10);
    @(posedge clk); @(posedge clk); #1;
    RstN = 1'b0;
    #1;
    check("midreset_readdata", bus.ReadData, 32'd0);
    check("midreset_irq", 32'(bus.Irq), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    RstN = 1'b1;
    model_reset();
    repeat (12) @(posedge clk);
    #1;
    bus_read(A_STAT, d);   check("midreset_status", d, 32'd0);
    bus_read(A_Y, d);      check("midreset_y", d, 32'd0);
    bus_read(A_CTRL, d);   check("midreset_ctrl", d, 32'd0);
    bus_read(A_COEF, d);   check("midreset_coef", d, 32'd0);
    bus_read(A_X, d);      check("midreset_xline", d, 32'd0);
    bus_read(15, d);       check("unmapped_read", d, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
